// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the reusable pipeline-stage register.
//   - Packed bundle widths for each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WR)
//   - Control-field offsets and the derived per-stage KILL_MASK constants
//   - 2-bit occupancy encoding of a stage register (EMPTY, ONE, FULL)
// ---------------------------------------------------------------------------
package pipe_pkg;

    // Packed bundle widths per stage boundary.
    localparam int IFID_W  = 64;
    localparam int IDEX_W  = 128;
    localparam int EXMEM_W = 96;
    localparam int MEMWR_W = 72;

    // Widest bundle any mask helper has to cover.
    localparam int MASK_MAX_W = 128;

    // Control fields sit at the bottom of each bundle so that the kill
    // masks stay stable when datapath fields are added above them.
    localparam int EXMEM_CP0OP_LSB = 0;
    localparam int EXMEM_CP0OP_W   = 3;
    localparam int EXMEM_REGWR_BIT = 3;
    localparam int EXMEM_MEMWR_BIT = 4;

    localparam int MEMWR_CP0OP_LSB = 0;
    localparam int MEMWR_CP0OP_W   = 3;
    localparam int MEMWR_REGWR_BIT = 3;

    // Contiguous run of 'width' ones starting at bit 'lsb'.
    function automatic logic [MASK_MAX_W-1:0] field_mask(input int lsb, input int width);
        logic [MASK_MAX_W-1:0] ones;
        ones = (MASK_MAX_W'(1) << width) - MASK_MAX_W'(1);
        return ones << lsb;
    endfunction

    // Killing a stage clears every field that would change architectural
    // state, so the instruction continues as a harmless bubble.
    localparam logic [EXMEM_W-1:0] EXMEM_KILL_MASK = EXMEM_W'(
        field_mask(EXMEM_CP0OP_LSB, EXMEM_CP0OP_W) |
        field_mask(EXMEM_REGWR_BIT, 1) |
        field_mask(EXMEM_MEMWR_BIT, 1));

    localparam logic [MEMWR_W-1:0] MEMWR_KILL_MASK = MEMWR_W'(
        field_mask(MEMWR_CP0OP_LSB, MEMWR_CP0OP_W) |
        field_mask(MEMWR_REGWR_BIT, 1));

    // Occupancy of a stage register: main entry only, or main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// ---------------------------------------------------------------------------
// pipe_skid_entry
// One DATA_W-bit entry of a stage register with load / clear / mask controls.
// Priority at the clock edge: clear (to RESET_VAL) over load-then-mask.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (-> RESET_VAL)
//   i_clear         force the entry to RESET_VAL
//   i_load, i_data  capture i_data
//   i_kill          AND the value being written with ~MASK
//   o_data          registered entry contents
// ---------------------------------------------------------------------------
module pipe_skid_entry #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0,
    parameter logic [DATA_W-1:0]  MASK      = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_kill,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_next;

    // NOTE: every path through a combinational block must assign its
    // outputs; the leading default below is what keeps this latch-free.
    always_comb begin
        w_next = r_data;
        if (i_load) begin
            w_next = i_data;
        end
        // The mask applies to whatever is about to be stored: the held
        // value or the freshly loaded one.
        if (i_kill) begin
            w_next = w_next & ~MASK;
        end
        if (i_clear) begin
            w_next = RESET_VAL;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= RESET_VAL;
        end else begin
            r_data <= w_next;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Reusable pipeline-stage register with valid/ready flow control and a
// 2-entry skid buffer (main + skid), synchronous flush and field-selective
// kill of the main entry.
// Optional: define PIPE_STAGE_STALL_CNT_EN to add the saturating stall_cnt
// output (cycles with in_valid & !in_ready; cleared by rst only).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    upstream handshake; in_ready depends only on state
//   in_data              upstream bundle
//   out_valid/out_ready  downstream handshake
//   out_data             main entry
//   flush                drop both entries (highest priority)
//   kill                 AND the value written into main with ~KILL_MASK
//   stall_cnt            stall-cycle counter (PIPE_STAGE_STALL_CNT_EN only)
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  KILL_MASK = {DATA_W{1'b0}},
    parameter logic [DATA_W-1:0]  RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              kill
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    stage_state_e      r_state;
    stage_state_e      w_state_next;

    logic              w_main_valid;
    logic              w_skid_valid;
    logic              w_accept;
    logic              w_emit;

    logic              w_main_load;
    logic              w_main_from_skid;
    logic              w_main_clear;
    logic              w_main_kill;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic [DATA_W-1:0] w_main_load_data;
    logic [DATA_W-1:0] w_skid_data;

    assign w_main_valid = (r_state != ST_EMPTY);
    assign w_skid_valid = (r_state == ST_FULL);

    // in_ready comes straight from state, so a downstream stall never
    // reaches the upstream stage combinationally.
    assign in_ready  = ~w_skid_valid;
    assign out_valid = w_main_valid;

    assign w_accept = in_valid & in_ready;
    assign w_emit   = w_main_valid & out_ready;

    // Kill only matters for a live entry; on an empty stage it is ignored.
    assign w_main_kill = kill & w_main_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_main_clear     = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;

        if (flush) begin
            // Any concurrent accept is dropped; a concurrent emit has
            // already happened on the bus this cycle.
            w_state_next = ST_EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_main_load  = 1'b1;
                        w_state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_emit) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        w_skid_load  = 1'b1;
                        w_state_next = ST_FULL;
                    end else if (w_emit) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_emit) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                        w_state_next     = ST_ONE;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                end
            endcase
        end
    end

    assign w_main_load_data = w_main_from_skid ? w_skid_data : in_data;

    pipe_skid_entry #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL),
        .MASK      (KILL_MASK)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_main_clear),
        .i_load  (w_main_load),
        .i_data  (w_main_load_data),
        .i_kill  (w_main_kill),
        .o_data  (out_data)
    );

    // The skid entry is never masked; kill acts when it is promoted.
    pipe_skid_entry #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL),
        .MASK      ({DATA_W{1'b0}})
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_skid_clear),
        .i_load  (w_skid_load),
        .i_data  (in_data),
        .i_kill  (1'b0),
        .o_data  (w_skid_data)
    );

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = in_valid & ~in_ready;

    // Flush deliberately leaves the count alone; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg (DATA_W=32, KILL_MASK=0xFF, RESET_VAL=0).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        flush;
    logic        kill;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(
        .DATA_W    (32),
        .KILL_MASK (32'h0000_00FF),
        .RESET_VAL (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .kill      (kill)
`ifdef PIPE_STAGE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        flush     = 1'b0;
        kill      = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_data",  out_data,           32'h0);
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt,          32'd0);
`endif
        step();
        rst = 1'b0;

        // Streaming: 1,2,3 with out_ready=1, one-cycle latency, no skid use
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'd1;
        step();
        check("stream1_valid", {31'd0, out_valid}, 32'd1);
        check("stream1_data",  out_data,           32'd1);
        check("stream1_ready", {31'd0, in_ready},  32'd1);
        in_data = 32'd2;
        step();
        check("stream2_data",  out_data,           32'd2);
        check("stream2_ready", {31'd0, in_ready},  32'd1);
        in_data = 32'd3;
        step();
        check("stream3_data",  out_data,           32'd3);
        check("stream3_ready", {31'd0, in_ready},  32'd1);
        in_valid = 1'b0;
        step();
        check("stream_drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: A, B fill the stage; C is refused
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        check("bp_a_data",  out_data,           32'hA);
        check("bp_a_ready", {31'd0, in_ready},  32'd1);
        in_data = 32'hB;
        step();
        check("bp_full_ready", {31'd0, in_ready},  32'd0);
        check("bp_full_data",  out_data,           32'hA);
        in_data = 32'hC;
        step();
        check("bp_c_ready", {31'd0, in_ready},  32'd0);
        check("bp_c_data",  out_data,           32'hA);
        check("bp_c_valid", {31'd0, out_valid}, 32'd1);
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("bp_stall_cnt", stall_cnt, 32'd1);
`endif
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_b_data",  out_data,           32'hB);
        check("bp_b_valid", {31'd0, out_valid}, 32'd1);
        check("bp_b_ready", {31'd0, in_ready},  32'd1);
        step();
        check("bp_empty_valid", {31'd0, out_valid}, 32'd0);

        // Kill on a held entry: low byte zeroed, entry stays valid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1234_56FF;
        step();
        check("kill_pre_data", out_data, 32'h1234_56FF);
        in_valid = 1'b0;
        kill     = 1'b1;
        step();
        kill = 1'b0;
        check("kill_held_data",  out_data,           32'h1234_5600);
        check("kill_held_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        step();
        check("kill_drain_valid", {31'd0, out_valid}, 32'd0);

        // Kill during skid promotion: promoted value is masked
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1111_11AA;
        step();
        in_data = 32'h2222_22BB;
        step();
        check("killp_full_ready", {31'd0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        kill      = 1'b1;
        step();
        kill = 1'b0;
        check("killp_data",  out_data,           32'h2222_2200);
        check("killp_valid", {31'd0, out_valid}, 32'd1);
        step();
        check("killp_drain_valid", {31'd0, out_valid}, 32'd0);

        // Flush while FULL with a simultaneous offer of 0x55
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        step();
        in_data = 32'h2;
        step();
        in_data = 32'h55;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_ready", {31'd0, in_ready},  32'd1);
        check("flush_data",  out_data,           32'h0);
        out_ready = 1'b1;
        step();
        check("flush_no55_valid", {31'd0, out_valid}, 32'd0);
`ifdef PIPE_STAGE_STALL_CNT_EN
        // Stalls so far: C refused once, 0x55 refused at the flush edge
        check("flush_stall_cnt", stall_cnt, 32'd2);
`endif

        // Asynchronous reset mid-transfer while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h77;
        step();
        in_data = 32'h88;
        step();
        check("arst_pre_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_ready", {31'd0, in_ready},  32'd1);
        check("arst_data",  out_data,           32'h0);
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("arst_stall_cnt", stall_cnt, 32'd0);
`endif
        #2;
        rst = 1'b0;

`ifdef PIPE_STAGE_STALL_CNT_EN
        // Hold FULL with in_valid=1 for five edges, then flush
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h3;
        step();
        in_data = 32'h4;
        step();
        in_data = 32'h5;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check("stall_cnt_5", stall_cnt, 32'd5);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        check("stall_cnt_after_flush", stall_cnt, 32'd5);
        check("stall_flush_valid", {31'd0, out_valid}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
